// File: rtl/data_memory_reader_if.sv
//------------------------------------------------------------------------------
// data_memory_reader_if
//
// Purpose : bundles the command, bank-read and halfword-stream signals of the
//           data memory reader so they travel as a single port.
//
// Signals :
//   start, start_addr, length   command from the controller
//   busy, done                  transfer status
//   addr_even, addr_odd, rd_en  read side of the two byte banks
//   data_even, data_odd         bank read data, one cycle after rd_en
//   out_valid, out_ready,
//   out_data                    halfword stream
//   checksum                    running sum of accepted halfwords (optional)
//   state_dbg                   current FSM state, for observation only
//
// Modports:
//   slave  - the reader itself
//   master - the environment driving commands, banks and the sink
//------------------------------------------------------------------------------
interface data_memory_reader_if #(
   parameter int BANK_AW = 8,
   parameter int LEN_W   = 9
);
   logic               start;
   logic [BANK_AW:0]   start_addr;
   logic [LEN_W-1:0]   length;
   logic               busy;
   logic               done;
   logic [BANK_AW-1:0] addr_even;
   logic [BANK_AW-1:0] addr_odd;
   logic               rd_en;
   logic [7:0]         data_even;
   logic [7:0]         data_odd;
   logic               out_valid;
   logic               out_ready;
   logic [15:0]        out_data;
   logic [15:0]        checksum;
   logic [1:0]         state_dbg;

   modport slave (
      input  start, start_addr, length, data_even, data_odd, out_ready,
      output busy, done, addr_even, addr_odd, rd_en, out_valid, out_data,
             checksum, state_dbg
   );

   modport master (
      output start, start_addr, length, data_even, data_odd, out_ready,
      input  busy, done, addr_even, addr_odd, rd_en, out_valid, out_data,
             checksum, state_dbg
   );
endinterface

// File: rtl/data_memory_reader.sv
//------------------------------------------------------------------------------
// data_memory_reader
//
// Purpose : second-port read engine for the split even/odd byte-bank data
//           memory. On a start command it streams `length` halfwords starting
//           at byte address `start_addr` (any alignment) over a valid/ready
//           interface. Byte order and unaligned reassembly match the core's
//           halfword load; addresses wrap modulo 2^(BANK_AW+1).
//
// Ports   :
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset
//   bus    - data_memory_reader_if.slave (command, bank read, output stream,
//            checksum, state_dbg)
//
// Handshake: a halfword transfers on every rising edge where out_valid and
//   out_ready are both high. out_valid/out_data come from the FIFO head and
//   stay stable until accepted; out_valid never depends on out_ready.
//
// Optional: define DATA_MEMORY_READER_CHECKSUM_EN to build the 16-bit
//   wrapping checksum of accepted halfwords; otherwise checksum is tied to 0.
//------------------------------------------------------------------------------
module data_memory_reader #(
   parameter int BANK_AW    = 8,
   parameter int LEN_W      = 9,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   data_memory_reader_if.slave  bus
);

   localparam int AW1   = BANK_AW + 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int OW    = CNT_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   state_e             state_q;
   logic [BANK_AW:0]   cur_q;
   logic [LEN_W-1:0]   length_q;
   logic [LEN_W-1:0]   issued_q;
   logic [LEN_W-1:0]   remaining_q;
   // pend_q marks bank data on data_even/data_odd this cycle; pend_odd_q
   // remembers the alignment of that read for byte reassembly.
   logic               pend_q;
   logic               pend_odd_q;

   logic [15:0]        fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;

   logic               pop;
   logic               push;
   logic               issue;
   logic [OW-1:0]      occ_after_pop;
   logic [15:0]        push_data;
   logic [BANK_AW-1:0] addr_base;

   assign pop  = (count_q != '0) && bus.out_ready;
   assign push = pend_q;

   // Occupancy the next read would join: buffered entries plus the read on the
   // bus, minus an entry leaving this cycle. Counting the same-cycle pop is
   // what allows one halfword per cycle with only two buffer entries.
   assign occ_after_pop = OW'(count_q) + OW'(pend_q) - OW'(pop);

   assign issue = (state_q == ST_RUN) && (issued_q != length_q) &&
                  (occ_after_pop < OW'(FIFO_DEPTH));

   assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

   // Odd start: the low byte comes from the odd bank at a>>1, the high byte
   // from the next even word (wrapping to even[0] at the top of memory).
   assign addr_base     = cur_q[BANK_AW:1];
   assign bus.addr_odd  = addr_base;
   assign bus.addr_even = cur_q[0] ? (addr_base + BANK_AW'(1)) : addr_base;
   assign bus.rd_en     = issue;

   assign push_data = pend_odd_q ? {bus.data_even, bus.data_odd}
                                 : {bus.data_odd,  bus.data_even};

   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = (count_q != '0) ? fifo_q[rd_ptr_q] : 16'h0000;
   assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign bus.done      = (state_q == ST_FIN);
   assign bus.state_dbg = state_q;

   // FIFO storage needs no reset: entries are only visible when count_q says so.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cur_q       <= '0;
         length_q    <= '0;
         issued_q    <= '0;
         remaining_q <= '0;
         pend_q      <= 1'b0;
         pend_odd_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         count_q <= count_d;
         pend_q  <= issue;
         if (issue) begin
            pend_odd_q <= cur_q[0];
            cur_q      <= cur_q + AW1'(2);
            issued_q   <= issued_q + LEN_W'(1);
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
            remaining_q <= remaining_q - LEN_W'(1);
         end

         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (bus.length != '0) begin
                     cur_q       <= bus.start_addr;
                     length_q    <= bus.length;
                     remaining_q <= bus.length;
                     issued_q    <= '0;
                     state_q     <= ST_RUN;
                  end else begin
                     state_q <= ST_FIN;
                  end
               end
            end
            ST_RUN: begin
               if (pop && (remaining_q == LEN_W'(1))) begin
                  state_q <= ST_FIN;
               end else if (issue && (issued_q == length_q - LEN_W'(1))) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (pop && (remaining_q == LEN_W'(1))) begin
                  state_q <= ST_FIN;
               end
            end
            ST_FIN: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef DATA_MEMORY_READER_CHECKSUM_EN
   logic [15:0] sum_q;

   // Clears on an accepted start (including zero length) and then holds after
   // the last handshake until the next start.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= 16'h0000;
      end else if ((state_q == ST_IDLE) && bus.start) begin
         sum_q <= 16'h0000;
      end else if (pop) begin
         sum_q <= sum_q + bus.out_data;
      end
   end

   assign bus.checksum = sum_q;
`else
   assign bus.checksum = 16'h0000;
`endif

endmodule
